// File: rtl/assert_handshake_multi_pkg.sv
// Shared types and constants for the multi-channel req/ack handshake checker.
package assert_handshake_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ACK,
    ST_ACK,
    ST_RECOVER
  } ch_state_e;

  localparam int CODE_W = 3;

  localparam logic [CODE_W-1:0] CODE_NONE            = 3'd0;
  localparam logic [CODE_W-1:0] CODE_ACK_WITHOUT_REQ = 3'd1;
  localparam logic [CODE_W-1:0] CODE_MULTI_REQ       = 3'd2;
  localparam logic [CODE_W-1:0] CODE_MIN_ACK         = 3'd3;
  localparam logic [CODE_W-1:0] CODE_MAX_ACK         = 3'd4;
  localparam logic [CODE_W-1:0] CODE_REQ_DROP        = 3'd5;
  localparam logic [CODE_W-1:0] CODE_DEASSERT        = 3'd6;
  localparam logic [CODE_W-1:0] CODE_ACK_LENGTH      = 3'd7;

  // One flag per violation code, indexed by the code value itself.
  typedef logic [7:1] viol_t;

  function automatic logic [CODE_W-1:0] lowest_code(input viol_t viol);
    lowest_code = CODE_NONE;
    for (int i = 7; i >= 1; i--) begin
      if (viol[i]) lowest_code = i[CODE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/assert_handshake_multi_ch.sv
// One handshake channel: protocol FSM, latency/length counter and fire register.
// X/Z detection on req/ack is compiled in when OVL_HANDSHAKE_XCHECK_EN is defined.
module assert_handshake_multi_ch
  import assert_handshake_multi_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int MIN_ACK_CYCLE  = 0,
  parameter int MAX_ACK_CYCLE  = 0,
  parameter int REQ_DROP       = 0,
  parameter int DEASSERT_COUNT = 0,
  parameter int MAX_ACK_LENGTH = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              req,
  input  logic              ack,
  output logic              busy,
  output logic              fire,
  output logic [CODE_W-1:0] fire_code
);

  // Limits are compared one bit wider than the counter so LIMIT+1 never wraps.
  localparam logic [CNT_W:0] MIN_LIM  = (CNT_W+1)'(MIN_ACK_CYCLE);
  localparam logic [CNT_W:0] MAX_LIM  = (CNT_W+1)'(MAX_ACK_CYCLE + 1);
  localparam logic [CNT_W:0] DA_LIM   = (CNT_W+1)'(DEASSERT_COUNT + 1);
  localparam logic [CNT_W:0] ALEN_LIM = (CNT_W+1)'(MAX_ACK_LENGTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ch_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_W:0]    cnt_ext;
  logic              req_prev_q, req_prev_d;
  logic              da_done_q, da_done_d;
  logic              alen_done_q, alen_done_d;
  logic              fire_q, fire_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              rise;
  viol_t             viol;

  assign rise    = req & ~req_prev_q;
  assign cnt_ext = {1'b0, cnt_q};
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_prev_d  = req;
    da_done_d   = da_done_q;
    alen_done_d = alen_done_q;
    viol        = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          cnt_d = CNT_ONE;
          if (ack) begin
            state_d     = ST_ACK;
            da_done_d   = 1'b0;
            alen_done_d = 1'b0;
            viol[CODE_MIN_ACK] = (MIN_ACK_CYCLE != 0);
          end else begin
            state_d = ST_WAIT_ACK;
          end
        end else if (ack) begin
          viol[CODE_ACK_WITHOUT_REQ] = 1'b1;
        end
      end

      ST_WAIT_ACK: begin
        viol[CODE_MULTI_REQ] = rise;
        if (ack) begin
          state_d     = ST_ACK;
          cnt_d       = CNT_ONE;
          da_done_d   = 1'b0;
          alen_done_d = 1'b0;
          viol[CODE_MIN_ACK] = (MIN_ACK_CYCLE != 0) && (cnt_ext < MIN_LIM);
        end else begin
          viol[CODE_MAX_ACK]   = (MAX_ACK_CYCLE != 0) && (cnt_ext == MAX_LIM);
          viol[CODE_REQ_DROP]  = (REQ_DROP != 0) && !req;
          if (viol[CODE_MAX_ACK] || viol[CODE_REQ_DROP]) begin
            state_d = ST_RECOVER;
          end else if (!rise) begin
            cnt_d = cnt_inc;
          end
        end
      end

      ST_ACK: begin
        viol[CODE_MULTI_REQ] = rise;
        if ((DEASSERT_COUNT != 0) && !da_done_q && req && (cnt_ext == DA_LIM)) begin
          viol[CODE_DEASSERT] = 1'b1;
          da_done_d           = 1'b1;
        end
        if ((MAX_ACK_LENGTH != 0) && !alen_done_q && ack && (cnt_ext == ALEN_LIM)) begin
          viol[CODE_ACK_LENGTH] = 1'b1;
          alen_done_d           = 1'b1;
        end
        if (!ack) state_d = ST_IDLE;
        else      cnt_d   = cnt_inc;
      end

      ST_RECOVER: begin
        if (!req && !ack) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    fire_d = enable && (|viol);
    code_d = fire_d ? lowest_code(viol) : code_q;

`ifdef OVL_HANDSHAKE_XCHECK_EN
    // An unknown input freezes the channel for that cycle and reports code 0.
    if (enable && $isunknown({req, ack})) begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_prev_d  = req_prev_q;
      da_done_d   = da_done_q;
      alen_done_d = alen_done_q;
      fire_d      = 1'b1;
      code_d      = CODE_NONE;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_prev_q  <= 1'b0;
      da_done_q   <= 1'b0;
      alen_done_q <= 1'b0;
      fire_q      <= 1'b0;
      code_q      <= CODE_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_prev_q  <= req_prev_d;
      da_done_q   <= da_done_d;
      alen_done_q <= alen_done_d;
      fire_q      <= fire_d;
      code_q      <= code_d;
    end
  end

  assign busy      = (state_q == ST_WAIT_ACK) || (state_q == ST_ACK);
  assign fire      = fire_q;
  assign fire_code = code_q;

endmodule

// File: rtl/assert_handshake_multi.sv
// Multi-channel req/ack handshake checker: one independent checker per channel.
// Optional X/Z input detection is enabled by defining OVL_HANDSHAKE_XCHECK_EN.
module assert_handshake_multi
  import assert_handshake_multi_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 8,
  parameter int MIN_ACK_CYCLE  = 0,
  parameter int MAX_ACK_CYCLE  = 0,
  parameter int REQ_DROP       = 0,
  parameter int DEASSERT_COUNT = 0,
  parameter int MAX_ACK_LENGTH = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        ack,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        fire,
  output logic [CODE_W*NUM_CH-1:0] fire_code
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("assert_handshake_multi: NUM_CH must be >= 1");
  end
  if ((CNT_W < 1) || (CNT_W > 30)) begin : g_bad_cnt_w
    $error("assert_handshake_multi: CNT_W must be in 1..30");
  end
  if ((MIN_ACK_CYCLE < 0) || (MIN_ACK_CYCLE >= (1 << CNT_W)) ||
      (MAX_ACK_CYCLE < 0) || (MAX_ACK_CYCLE >= (1 << CNT_W)) ||
      (DEASSERT_COUNT < 0) || (DEASSERT_COUNT >= (1 << CNT_W)) ||
      (MAX_ACK_LENGTH < 0) || (MAX_ACK_LENGTH >= (1 << CNT_W))) begin : g_bad_limit
    $error("assert_handshake_multi: every limit must lie in 0..2**CNT_W-1");
  end
  if ((MAX_ACK_CYCLE != 0) && (MAX_ACK_CYCLE < MIN_ACK_CYCLE)) begin : g_bad_min_max
    $error("assert_handshake_multi: MAX_ACK_CYCLE must be >= MIN_ACK_CYCLE");
  end
  if ((REQ_DROP != 0) && (REQ_DROP != 1)) begin : g_bad_req_drop
    $error("assert_handshake_multi: REQ_DROP must be 0 or 1");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assert_handshake_multi_ch #(
      .CNT_W          (CNT_W),
      .MIN_ACK_CYCLE  (MIN_ACK_CYCLE),
      .MAX_ACK_CYCLE  (MAX_ACK_CYCLE),
      .REQ_DROP       (REQ_DROP),
      .DEASSERT_COUNT (DEASSERT_COUNT),
      .MAX_ACK_LENGTH (MAX_ACK_LENGTH)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .req       (req[c]),
      .ack       (ack[c]),
      .busy      (busy[c]),
      .fire      (fire[c]),
      .fire_code (fire_code[CODE_W*c +: CODE_W])
    );
  end

endmodule

// File: doc/assert_handshake_multi.md
Name: assert_handshake_multi

Overview:
- Multi-channel, fully synthesisable req/ack handshake checker; successor to the single-channel PSL-bound handshake checker.
- Each of NUM_CH independent channels runs its own protocol FSM and latency/length counters.
- Reports a one-cycle fire pulse plus a violation code per channel.
- Sits in the OVL checker library; instantiated beside DUT handshakes or in formal harnesses that have no PSL.

Parameters:
- NUM_CH, 4, number of independent req/ack channels (>=1)
- CNT_W, 8, counter width; all limits below must be < 2**CNT_W (elaboration error otherwise)
- MIN_ACK_CYCLE, 0, minimum req-to-ack latency L; 0 disables check
- MAX_ACK_CYCLE, 0, maximum L; 0 disables check; must be >= MIN_ACK_CYCLE when nonzero
- REQ_DROP, 0, 1 = req must stay high until ack
- DEASSERT_COUNT, 0, 1..N = req must fall within N cycles after ack asserts; 0 disables
- MAX_ACK_LENGTH, 0, max consecutive ack-high cycles; 0 disables

Ports:
- clk  input  1  sampling clock, rising edge
- reset_n  input  1  synchronous, active-low reset
- enable  input  1  0 = checks suppressed; FSMs still track
- req  input  NUM_CH  request per channel
- ack  input  NUM_CH  acknowledge per channel
- busy  output  NUM_CH  channel in WAIT_ACK or ACK
- fire  output  NUM_CH  registered one-cycle violation pulse
- fire_code  output  3*NUM_CH  violation code per channel, slice [3c+2:3c]

Behaviour:
- Reset (reset_n=0 at posedge): all FSMs IDLE, counters 0, req history 0; busy, fire, fire_code = 0. Applies mid-operation; no fire on the reset cycle or the first cycle after it.
- Rise is defined as req=1 with previous sampled req=0. Latency L = cycles from rise sample to first ack=1 sample (L>=1 if ack follows rise; ack on the rise cycle gives L=0).
- FSM states:
  - IDLE:
    - rise & !ack -> WAIT_ACK, cnt=1.
    - rise & ack -> ACK (L=0, MIN check applies).
    - ack=1 without rise -> ACK_WITHOUT_REQ; stay IDLE.
  - WAIT_ACK:
    - ack=1 -> ACK; fire MIN_ACK if MIN_ACK_CYCLE!=0 & cnt<MIN_ACK_CYCLE; cnt reset to 1 for ack length.
    - else cnt++ (saturating).
    - MAX_ACK_CYCLE!=0 & cnt==MAX_ACK_CYCLE+1 without ack -> fire MAX_ACK, go RECOVER.
    - REQ_DROP=1 & req=0 -> fire REQ_DROP, go RECOVER.
    - rise (req fell and returned, REQ_DROP=0) -> fire MULTI_REQ, stay, cnt unchanged.
  - ACK:
    - ack=0 -> IDLE.
    - MAX_ACK_LENGTH!=0 & cnt==MAX_ACK_LENGTH+1 -> fire ACK_LENGTH once per ack pulse.
    - DEASSERT_COUNT!=0 & req still 1 when cnt==DEASSERT_COUNT+1 -> fire DEASSERT once.
    - rise -> fire MULTI_REQ.
  - RECOVER: wait req=0 & ack=0, then IDLE; no further checks in this state.
- Fire timing: registered; the cycle after the violating sample. Pulse is 1 cycle; fire_code is held to the last code until the next fire.
- Simultaneous violations in one channel: lowest code wins. Codes: 1 ACK_WITHOUT_REQ, 2 MULTI_REQ, 3 MIN_ACK, 4 MAX_ACK, 5 REQ_DROP, 6 DEASSERT, 7 ACK_LENGTH (XZ uses 0 with fire=1, see feature).
- Channels are fully independent; simultaneous fires on different channels are all reported.
- enable=0: fire forced 0; state transitions unchanged.

Optional Feature:
- Macro: OVL_HANDSHAKE_XCHECK_EN.
- Defined: req or ack bit X/Z at posedge with reset_n=1 and enable=1 -> fire=1, fire_code=0 for that channel next cycle; FSM holds state that cycle.
- Undefined: no X/Z detection logic; 4-state semantics only; code 0 never reported with fire.

Decomposition:
- Package assert_handshake_multi_pkg: state enum (IDLE, WAIT_ACK, ACK, RECOVER), 3-bit fire code constants, code width localparam.
- Sub-module assert_handshake_multi_ch: one channel FSM + counter + fire register.
- Top is a generate loop over NUM_CH plus parameter legality checks.

Test Plan:
- MIN=2, MAX=4, ch0 req rise at t0, ack at t0+3 -> no fire; busy high t0+1..ack fall.
- Same params, ch1 ack at t0+1 -> fire[1]=1, code=3 at t0+2; ack never -> code=4 at t0+6.
- REQ_DROP=1, ch2 req falls at t0+2 before ack -> code=5 at t0+3; RECOVER until req/ack low.
- DEASSERT_COUNT=2, MAX_ACK_LENGTH=3, ack at ta, req and ack held high -> code=6 at ta+4, code=7 at ta+5.
- ack pulse on ch3 with req=0; ch0 req and ack rise same cycle as ch3 ack -> fire[3] code=1, fire[0]=0.
- Reset asserted in WAIT_ACK past MAX -> no fire; all outputs 0 two cycles after reset release; XCHECK build: req=X -> code 0 fire.
